// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer block.
package countdown_timer_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESCALE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a tick on the enabled cycle where the count reaches PRESCALE-1.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = enable && at_last;

  // clear has priority; a disabled prescaler simply holds its phase
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable)
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with pause/resume, optional auto-reload and a prescaled tick.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] remaining,
  output logic             running,
  output logic             expired,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             running_q, expired_q, done_q, expired_d;
  logic             tick, pre_en;

  // The prescaler only advances on cycles that actually count; load/stop freeze it
  assign pre_en = (state_q == ST_RUN) && !load && !stop;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (pre_en),
    .clear  (load),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    expired_d   = 1'b0;
    if (load) begin
      remaining_d = load_value;
      reload_d    = load_value;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stop && start && remaining_q != '0) state_d = ST_RUN;
        end
        ST_PAUSE: begin
          if (!stop && start && remaining_q != '0) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (remaining_q > WIDTH'(1)) begin
              remaining_d = remaining_q - WIDTH'(1);
            end else if (remaining_q == WIDTH'(1)) begin
              expired_d = 1'b1;
              if (auto_reload && reload_q != '0) begin
                remaining_d = reload_q;
              end else begin
                remaining_d = '0;
                state_d     = ST_DONE;
              end
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        default: ; // DONE: only load or reset leave
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      running_q   <= (state_d == ST_RUN);
      expired_q   <= expired_d;
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign remaining = remaining_q;
  assign running   = running_q;
  assign expired   = expired_q;
  assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: one timer at PRESCALE=1 and one at PRESCALE=4 sharing stimulus.
module tb_countdown_timer;
  import countdown_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, start, stop, auto_reload;
  logic [7:0] load_value;
  logic [7:0] rem1, rem4;
  logic       run1, run4, exp1, exp4, done1, done4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .remaining(rem1), .running(run1), .expired(exp1), .done(done1)
  );

  countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .remaining(rem4), .running(run4), .expired(exp4), .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks all four outputs of the PRESCALE=1 instance
  task automatic chk1(input string tag, input int r, input bit ru, input bit ex, input bit dn);
    chk({tag, ".rem"},  32'(rem1),  32'(r));
    chk({tag, ".run"},  32'(run1),  32'(ru));
    chk({tag, ".exp"},  32'(exp1),  32'(ex));
    chk({tag, ".done"}, 32'(done1), 32'(dn));
  endtask

  task automatic chk4(input string tag, input int r, input bit ru, input bit ex, input bit dn);
    chk({tag, ".rem"},  32'(rem4),  32'(r));
    chk({tag, ".run"},  32'(run4),  32'(ru));
    chk({tag, ".exp"},  32'(exp4),  32'(ex));
    chk({tag, ".done"}, 32'(done4), 32'(dn));
  endtask

  // Advance one active edge, then settle before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; load = 0; start = 0; stop = 0; auto_reload = 0; load_value = '0;
    #12;
    chk1("reset1", 0, 0, 0, 0);
    chk4("reset4", 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Basic countdown from 5 to DONE
    load = 1; load_value = 8'd5; step();
    load = 0; chk1("ld5", 5, 0, 0, 0);
    start = 1; step(); start = 0;
    chk1("e0", 5, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(); chk1($sformatf("e%0d", i), 5 - i, 1, 0, 0);
    end
    step(); chk1("e5", 0, 0, 1, 1);
    step(); chk1("e6", 0, 0, 0, 1);
    start = 1; step(); start = 0;
    chk1("start_in_done", 0, 0, 0, 1);

    // Pause and resume
    load = 1; load_value = 8'd10; step(); load = 0;
    chk1("ld10", 10, 0, 0, 0);
    start = 1; step(); start = 0;
    step(); step(); step();
    chk1("3ticks", 7, 1, 0, 0);
    stop = 1; step(); stop = 0;
    chk1("paused", 7, 0, 0, 0);
    step(); step(); step(); step();
    chk1("hold4", 7, 0, 0, 0);
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk1("startstop_pause", 7, 0, 0, 0);
    start = 1; step(); start = 0;
    chk1("resume", 7, 1, 0, 0);
    step(); chk1("res6", 6, 1, 0, 0);
    step(); chk1("res5", 5, 1, 0, 0);

    // Auto-reload: load 3, seven ticks
    auto_reload = 1;
    load = 1; load_value = 8'd3; step(); load = 0;
    start = 1; step(); start = 0;
    chk1("ar_start", 3, 1, 0, 0);
    step(); chk1("ar1", 2, 1, 0, 0);
    step(); chk1("ar2", 1, 1, 0, 0);
    step(); chk1("ar3", 3, 1, 1, 0);
    step(); chk1("ar4", 2, 1, 0, 0);
    step(); chk1("ar5", 1, 1, 0, 0);
    step(); chk1("ar6", 3, 1, 1, 0);
    step(); chk1("ar7", 2, 1, 0, 0);
    auto_reload = 0;

    // Load 0 then start: remains idle
    load = 1; load_value = 8'd0; step(); load = 0;
    start = 1; step(); start = 0;
    chk1("ld0_start", 0, 0, 0, 0);

    // Load coincident with an expiring tick: load wins, no pulse
    load = 1; load_value = 8'd1; step(); load = 0;
    start = 1; step(); start = 0;
    load = 1; load_value = 8'd9; step(); load = 0;
    chk1("ld_vs_expire", 9, 0, 0, 0);

    // PRESCALE=4: load 2
    load = 1; load_value = 8'd2; step(); load = 0;
    start = 1; step(); start = 0;
    chk4("p4_e0", 2, 1, 0, 0);
    step(); step(); step();
    chk4("p4_e3", 2, 1, 0, 0);
    step(); chk4("p4_e4", 1, 1, 0, 0);
    step(); step(); step();
    chk4("p4_e7", 1, 1, 0, 0);
    step(); chk4("p4_e8", 0, 0, 1, 1);
    step(); chk4("p4_e9", 0, 0, 0, 1);

    // Reset mid-RUN with remaining 6
    load = 1; load_value = 8'd10; step(); load = 0;
    start = 1; step(); start = 0;
    step(); step(); step(); step();
    chk1("pre_rst", 6, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk1("rst_async", 0, 0, 0, 0);
    step(); chk1("rst_hold", 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    load = 1; load_value = 8'd4; step(); load = 0;
    start = 1; step(); start = 0;
    chk1("post_rst_e0", 4, 1, 0, 0);
    step(); chk1("post_rst_e1", 3, 1, 0, 0);
    step(); step();
    chk1("post_rst_e3", 1, 1, 0, 0);
    step(); chk1("post_rst_e4", 0, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the count value.
REQ-002 SHALL have parameter PRESCALE, default 1 (legal value 1 or more): clk cycles per count tick.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port load, input, 1: capture load_value into the counter and reload register.
REQ-006 SHALL have port load_value, input, WIDTH: initial/reload count.
REQ-007 SHALL have port start, input, 1: begin or resume counting down.
REQ-008 SHALL have port stop, input, 1: pause counting.
REQ-009 SHALL have port auto_reload, input, 1: on expiry, reload and keep running.
REQ-010 SHALL have port remaining, output, WIDTH: current count, registered.
REQ-011 SHALL have port running, output, 1: high in RUN state.
REQ-012 SHALL have port expired, output, 1: one-cycle pulse on each expiry.
REQ-013 SHALL have port done, output, 1: level, high in DONE state.

Function
REQ-014 SHALL implement the states IDLE, RUN, PAUSE and DONE; outputs SHALL be registered and decoded from the state.
REQ-015 SHALL apply control priority on any edge as: load, then stop, then start.
REQ-016 load in any state SHALL set remaining and the reload register to load_value, clear the prescaler and move to IDLE.
REQ-017 start in IDLE or PAUSE with remaining nonzero SHALL move to RUN.
REQ-018 start with remaining equal to 0, or start in DONE, SHALL be ignored.
REQ-019 stop in RUN SHALL move to PAUSE and hold remaining and the prescaler count.
REQ-020 stop in any other state SHALL be ignored.
REQ-021 In RUN, a tick SHALL occur when the prescaler reaches PRESCALE-1; the prescaler SHALL then wrap to 0.
REQ-022 With PRESCALE=1, every RUN cycle SHALL be a tick.
REQ-023 Latency: start sampled at edge N SHALL set running after edge N; the first decrement SHALL occur at edge N+PRESCALE.
REQ-024 A tick with remaining greater than 1 SHALL decrement remaining by 1.
REQ-025 A tick with remaining equal to 1 and auto_reload=0 SHALL set remaining to 0, move to DONE and assert expired for exactly one cycle.
REQ-026 A tick with remaining equal to 1 and auto_reload=1 SHALL reload remaining from the reload register, stay in RUN and pulse expired.
REQ-027 remaining SHALL never underflow; there SHALL be no wrap below 0.
REQ-028 DONE SHALL be left only by load or reset.
REQ-029 load coincident with an expiring tick SHALL take the load behaviour, with no expired pulse.
REQ-030 start and stop asserted together SHALL take the stop behaviour (stop wins).

Reset
REQ-031 rst_n low SHALL asynchronously force state IDLE, remaining 0, reload register 0, prescaler 0, running 0, expired 0 and done 0.
REQ-032 Reset asserted mid-RUN SHALL abort the count immediately, with no expired pulse.
REQ-033 Reset release SHALL be synchronous to clk; the first active edge after release SHALL honour inputs.

Structure
REQ-034 The package countdown_timer_pkg SHALL hold the state enumeration and the default WIDTH and PRESCALE constants.
REQ-035 The prescaler SHALL be the sub-module tick_gen: inputs clk, rst_n, enable, clear; output tick.

Verification
REQ-036 PRESCALE=1: load 5, start at edge 0 -> remaining reads 4,3,2,1,0 after edges 1..5; expired high for the single cycle after edge 5; done=1 thereafter.
REQ-037 load 10, start, stop after 3 ticks, wait 4 cycles -> remaining holds 7; start -> resumes 6,5,...
REQ-038 auto_reload=1, load 3, run 7 ticks -> expired pulses after ticks 3 and 6; remaining reads 2 after tick 7; running stays 1.
REQ-039 PRESCALE=4, load 2, start -> first decrement 4 cycles after start; expiry 8 cycles after start.
REQ-040 Edge cases -> load 0 then start: state stays IDLE. start+stop together in PAUSE: stays PAUSE. start in DONE: ignored.
REQ-041 rst_n low mid-RUN with remaining 6 -> all outputs 0 immediately, with no expired pulse; after release, load 4 and start counts normally.
